// File: rtl/m_dmem_responder.sv
// m_dmem_responder: data-memory responder for the core load/store port.
// Accepts one request at a time over a valid/ready request channel, waits
// LATENCY cycles, commits the access and then holds the response until the
// initiator takes it.
//   w_clk, w_rst_n            clock, asynchronous active-low reset
//   w_req_valid/w_req_ready   request handshake
//   w_req_we/addr/wdata/be    store flag, byte address, store data, byte enables
//   w_rsp_valid/w_rsp_ready   response handshake
//   w_rsp_rdata/w_rsp_err     load data (0 for stores/errors), access error
module m_dmem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        w_clk,
   input  logic        w_rst_n,
   input  logic        w_req_valid,
   output logic        w_req_ready,
   input  logic        w_req_we,
   input  logic [31:0] w_req_addr,
   input  logic [31:0] w_req_wdata,
   input  logic [3:0]  w_req_be,
   output logic        w_rsp_valid,
   input  logic        w_rsp_ready,
   output logic [31:0] w_rsp_rdata,
   output logic        w_rsp_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} t_state;

   t_state        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_be;
   logic          r_req_ready;
   logic          r_rsp_valid;
   logic [31:0]   r_rsp_rdata;
   logic          r_rsp_err;
   logic [31:0]   r_mem [DEPTH] = '{default: '0};

   logic          w_idle;
   logic          w_accept;
   logic          w_commit;
   logic          w_c_we;
   logic [31:0]   w_c_addr;
   logic [31:0]   w_c_wdata;
   logic [3:0]    w_c_be;
   logic          w_c_err;
   logic [AW-1:0] w_c_idx;

   assign w_idle   = r_state == IDLE;
   assign w_accept = w_idle & w_req_valid & r_req_ready;
   // With zero latency the commit happens on the acceptance edge itself, so
   // the commit path reads the live request inputs while idle.
   assign w_commit = w_rst_n & ((w_accept & (LATENCY == 0)) | ((r_state == WAIT) & (r_cnt == '0)));
   assign w_c_we    = w_idle ? w_req_we    : r_we;
   assign w_c_addr  = w_idle ? w_req_addr  : r_addr;
   assign w_c_wdata = w_idle ? w_req_wdata : r_wdata;
   assign w_c_be    = w_idle ? w_req_be    : r_be;
   assign w_c_idx   = w_c_addr[AW+1:2];
   assign w_c_err   = (w_c_addr[1:0] != 2'b00) | (w_c_addr[31:AW+2] != '0);

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            // After a response handshake ready stays low for one idle cycle
            IDLE: if (!r_req_ready) r_req_ready <= 1'b1;
                  else if (w_req_valid) begin
                     r_we        <= w_req_we;
                     r_addr      <= w_req_addr;
                     r_wdata     <= w_req_wdata;
                     r_be        <= w_req_be;
                     r_req_ready <= 1'b0;
                     r_cnt       <= CNT_INIT;
                     r_state     <= (LATENCY == 0) ? RESP : WAIT;
                  end
            WAIT: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                  else r_state <= RESP;
            RESP: if (w_rsp_ready) begin
                     r_state     <= IDLE;
                     r_rsp_valid <= 1'b0;
                     r_rsp_rdata <= '0;
                     r_rsp_err   <= 1'b0;
                  end
            default: r_state <= IDLE;
         endcase
         if (w_commit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_c_err;
            r_rsp_rdata <= (w_c_err | w_c_we) ? '0 : r_mem[w_c_idx];
         end
      end
   end

   always_ff @(posedge w_clk) begin
      if (w_commit & w_c_we & ~w_c_err)
         for (int i = 0; i < 4; i++)
            if (w_c_be[i]) r_mem[w_c_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
   end

   assign w_req_ready = r_req_ready;
   assign w_rsp_valid = r_rsp_valid;
   assign w_rsp_rdata = r_rsp_rdata;
   assign w_rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_m_dmem_responder.sv
// tb_m_dmem_responder: directed bench for m_dmem_responder.
// Three instances share the request payload: LATENCY=2, 0 and 3 (index 0..2),
// each with its own valid, response-ready and reset.
module tb_m_dmem_responder;
   logic        clk = 1'b0;
   logic [2:0]  rst_n = 3'b000;
   logic [2:0]  req_valid = 3'b000;
   logic [2:0]  req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic [2:0]  rsp_valid;
   logic [2:0]  rsp_ready = 3'b000;
   logic [31:0] rsp_rdata [3];
   logic [2:0]  rsp_err;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      m_dmem_responder #(.DEPTH(64), .LATENCY(g == 0 ? 2 : (g == 1 ? 0 : 3))) u_dut (
         .w_clk      (clk),
         .w_rst_n    (rst_n[g]),
         .w_req_valid(req_valid[g]),
         .w_req_ready(req_ready[g]),
         .w_req_we   (req_we),
         .w_req_addr (req_addr),
         .w_req_wdata(req_wdata),
         .w_req_be   (req_be),
         .w_rsp_valid(rsp_valid[g]),
         .w_rsp_ready(rsp_ready[g]),
         .w_rsp_rdata(rsp_rdata[g]),
         .w_rsp_err  (rsp_err[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input int d);
      for (int i = 0; i < 20 && !req_ready[d]; i++) @(negedge clk);
      if (!req_ready[d]) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   // One full transaction with the response accepted as soon as it appears
   task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
      wait_ready(d);
      req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      req_valid[d] = 1'b1; rsp_ready[d] = 1'b1;
      @(posedge clk); #1 req_valid[d] = 1'b0;
      lat = 0; rd = '0; er = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (rsp_valid[d]) begin lat = i; break; end
      end
      if (lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
      rd = rsp_rdata[d]; er = rsp_err[d];
      @(posedge clk); #1;
   endtask

   task automatic st(input string tag, input int d, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic exp_err, input int exp_lat);
      logic [31:0] rd; logic er; int lat;
      txn(d, 1'b1, addr, wdata, be, rd, er, lat);
      chk({tag, "_rdata"}, rd, 32'h0);
      chk({tag, "_err"}, 32'(er), 32'(exp_err));
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic ld(input string tag, input int d, input logic [31:0] addr, input logic [31:0] exp_rd,
                     input logic exp_err, input int exp_lat);
      logic [31:0] rd; logic er; int lat;
      txn(d, 1'b0, addr, 32'h0, 4'h0, rd, er, lat);
      chk({tag, "_rdata"}, rd, exp_rd);
      chk({tag, "_err"}, 32'(er), 32'(exp_err));
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic pulse_reset(input int d);
      @(negedge clk); rst_n[d] = 1'b0;
      @(negedge clk); rst_n[d] = 1'b1;
   endtask

   initial begin
      int acc[$];
      int n;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[0], 32'h0);
      chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
      rst_n = 3'b111;
      @(negedge clk);
      // LATENCY=2 store/load and read-after-write
      st("st10", 0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 3);
      ld("ld10", 0, 32'h10, 32'hDEADBEEF, 1'b0, 3);
      // byte enables
      st("st20", 0, 32'h20, 32'h11223344, 4'hF, 1'b0, 3);
      st("st20be", 0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 3);
      ld("ld20", 0, 32'h20, 32'h11BB33DD, 1'b0, 3);
      // errors: misaligned load, out-of-range store aliasing word 0
      ld("ld102", 0, 32'h102, 32'h0, 1'b1, 3);
      st("st0", 0, 32'h0, 32'h12345678, 4'hF, 1'b0, 3);
      st("st100", 0, 32'h100, 32'hFFFFFFFF, 4'hF, 1'b1, 3);
      ld("ld0", 0, 32'h0, 32'h12345678, 1'b0, 3);
      // empty byte enable
      st("stbe0", 0, 32'h10, 32'h01010101, 4'h0, 1'b0, 3);
      ld("ld10b", 0, 32'h10, 32'hDEADBEEF, 1'b0, 3);
      // backpressure on a load response, with an intruding request
      wait_ready(0);
      req_we = 1'b0; req_addr = 32'h20; req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
      @(posedge clk); #1 req_valid[0] = 1'b0;
      n = 0;
      while (!rsp_valid[0] && n < 20) begin @(negedge clk); n++; end
      chk("bp_lat", 32'(n), 32'd3);
      req_we = 1'b1; req_wdata = 32'hFFFFFFFF; req_be = 4'hF; req_valid[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", 32'(rsp_valid[0]), 32'd1);
         chk("bp_rdata", rsp_rdata[0], 32'h11BB33DD);
         chk("bp_err", 32'(rsp_err[0]), 32'd0);
         chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
      end
      req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp_hs_valid", 32'(rsp_valid[0]), 32'd0);
      chk("bp_hs_rdata", rsp_rdata[0], 32'h0);
      chk("bp_hs_ready0", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
      chk("bp_hs_ready1", 32'(req_ready[0]), 32'd1);
      ld("ld20b", 0, 32'h20, 32'h11BB33DD, 1'b0, 3);
      // LATENCY=0
      ld("z_ld10", 1, 32'h10, 32'h0, 1'b0, 1);
      st("z_st4", 1, 32'h4, 32'hCAFEF00D, 4'hF, 1'b0, 1);
      ld("z_ld4", 1, 32'h4, 32'hCAFEF00D, 1'b0, 1);
      wait_ready(1);
      req_we = 1'b0; req_addr = 32'h4; req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (req_ready[1]) acc.push_back(c);
      end
      req_valid[1] = 1'b0;
      chk("z_tp_count", 32'(acc.size()), 32'd4);
      for (int i = 1; i < acc.size(); i++) chk("z_tp_gap", 32'(acc[i] - acc[i-1]), 32'd3);
      wait_ready(1);
      // reset mid-WAIT drops the store (LATENCY=3)
      wait_ready(2);
      req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h55; req_be = 4'hF;
      req_valid[2] = 1'b1; rsp_ready[2] = 1'b1;
      @(posedge clk); #1 req_valid[2] = 1'b0;
      @(negedge clk); rst_n[2] = 1'b0;
      #1;
      chk("mr_req_ready", 32'(req_ready[2]), 32'd1);
      chk("mr_rsp_valid", 32'(rsp_valid[2]), 32'd0);
      chk("mr_rsp_rdata", rsp_rdata[2], 32'h0);
      chk("mr_rsp_err", 32'(rsp_err[2]), 32'd0);
      @(negedge clk); rst_n[2] = 1'b1;
      ld("mr_ld8", 2, 32'h8, 32'h0, 1'b0, 4);
      // a committed store survives reset
      st("mr_stc", 2, 32'hC, 32'h99, 4'hF, 1'b0, 4);
      pulse_reset(2);
      ld("mr_ldc", 2, 32'hC, 32'h99, 1'b0, 4);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
